// File: rtl/img_pkg.sv
// Shared definitions for the RGB image engine and its job scheduler:
// opcodes, scheduler state encoding and BMP-style header field offsets.
package img_pkg;

  localparam logic [1:0] BRIGHTNESS = 2'd0;
  localparam logic [1:0] GRAYSCALE  = 2'd1;
  localparam logic [1:0] ROTATE     = 2'd2;

  // Byte offsets of the geometry fields in the loaded frame header.
  localparam int unsigned HDR_WIDTH_OFS  = 18;
  localparam int unsigned HDR_HEIGHT_OFS = 22;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StReject,
    StLaunch,
    StRun,
    StFinish
  } sched_state_e;

  function automatic logic opcode_valid(input logic [1:0] op);
    return op <= ROTATE;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr+1 (mod NUM_REQ).
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       any
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  int unsigned k;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    k       = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      k = (32'(ptr) + i) % NUM_REQ;
      if (!any && req[k]) begin
        any     = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = IW'(k);
      end
    end
  end

endmodule

// File: rtl/img_op_scheduler.sv
// Round-robin job scheduler that launches the image engine through its reset.
// Optional RUN watchdog: define IMG_SCHED_TIMEOUT_EN.
module img_op_scheduler
  import img_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned MAX_WIDTH     = 1080,
  parameter int unsigned MAX_HEIGHT    = 1080,
  parameter int unsigned RST_HOLD      = 2,
  parameter int unsigned TIMEOUT_SLACK = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [2*NUM_REQ-1:0]   req_opcode,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   err,
  output logic                   busy,
  output logic                   eng_rst_n,
  output logic [1:0]             eng_opcode,
  input  logic                   eng_done,
  input  logic [31:0]            img_width,
  input  logic [31:0]            img_height
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned HW = $clog2(RST_HOLD) + 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || RST_HOLD < 1 || TIMEOUT_SLACK > 32'h7fff_ffff) begin : g_bad
    $error("img_op_scheduler: illegal parameter set");
  end

  sched_state_e        state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d, ack_q, ack_d;
  logic [IW-1:0]       owner_q, owner_d, ptr_q, ptr_d;
  logic [1:0]          opcode_q, opcode_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                to_q, to_d, err_q, err_d, eng_rst_q, eng_rst_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;
  logic [1:0]          pick_op;
  logic                geom_ok;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  assign pick_op = req_opcode[{arb_idx, 1'b0} +: 2];
  assign geom_ok = (img_width != 32'd0) && (img_height != 32'd0) &&
                   (img_width <= 32'(MAX_WIDTH)) && (img_height <= 32'(MAX_HEIGHT));

`ifdef IMG_SCHED_TIMEOUT_EN
  logic [63:0] run_limit;
  assign run_limit = 64'(img_width) * 64'(img_height) + 64'(TIMEOUT_SLACK);
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    opcode_d = opcode_q;
    hold_d   = hold_q;
    cnt_d    = cnt_q;
    to_d     = to_q;
    unique case (state_q)
      StIdle: if (|req) state_d = StArb;
      StArb: begin
        if (arb_any) begin
          grant_d  = arb_gnt;
          owner_d  = arb_idx;
          opcode_d = pick_op;
          hold_d   = '0;
          state_d  = (opcode_valid(pick_op) && geom_ok) ? StLaunch : StReject;
        end else begin
          state_d = StIdle;
        end
      end
      StReject: begin
        grant_d = '0;
        ptr_d   = owner_q;
        state_d = StIdle;
      end
      StLaunch: begin
        cnt_d = '0;
        if (hold_q == HW'(RST_HOLD - 1)) state_d = StRun;
        else hold_d = hold_q + HW'(1);
      end
      StRun: begin
        cnt_d = cnt_q + 32'd1;
        // done is not meaningful until the engine's start pulse has propagated
        if (eng_done && cnt_q >= 32'd2) begin
          state_d = StFinish;
`ifdef IMG_SCHED_TIMEOUT_EN
        end else if ({32'd0, cnt_q} >= run_limit) begin
          state_d = StFinish;
          to_d    = 1'b1;
`endif
        end
      end
      StFinish: begin
        grant_d = '0;
        ptr_d   = owner_q;
        to_d    = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Outputs registered off the next state so the engine reset never glitches.
    eng_rst_d = (state_d == StRun);
    ack_d     = (state_d == StReject || state_d == StFinish) ? grant_d : '0;
    err_d     = (state_d == StReject) || (state_d == StFinish && to_d);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= IW'(NUM_REQ - 1);
      opcode_q  <= '0;
      hold_q    <= '0;
      cnt_q     <= '0;
      to_q      <= 1'b0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      eng_rst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      opcode_q  <= opcode_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      eng_rst_q <= eng_rst_d;
    end
  end

  assign grant      = grant_q;
  assign ack        = ack_q;
  assign err        = err_q;
  assign busy       = (state_q != StIdle);
  assign eng_rst_n  = eng_rst_q;
  assign eng_opcode = opcode_q;

endmodule
